// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial system bus: FSM state encoding,
// default field widths and the bit-counter width helper.
package bus_pkg;

  localparam int SLAVE_LEN_DEF = 2;
  localparam int ADDR_LEN_DEF  = 12;
  localparam int DATA_LEN_DEF  = 8;
  localparam int BURST_LEN_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_HDR,
    ST_WR_DATA,
    ST_WR_COMMIT,
    ST_RD_FETCH,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  // Bits needed to count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port register array with synchronous write and registered read.
module slave_mem #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];

  // NOTE: storage has no reset; clearing thousands of flops buys nothing,
  // and committed words must survive a port reset anyway.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/slave_port.sv
// Bit-serial bus slave: header decode, burst write into local memory and
// handshaked serial read-back. Define SLAVE_PORT_PARITY_EN for even word parity.
module slave_port
  import bus_pkg::*;
#(
  parameter int SLAVE_LEN    = SLAVE_LEN_DEF,
  parameter int SLAVE_ID     = 0,
  parameter int ADDR_LEN     = ADDR_LEN_DEF,
  parameter int DATA_LEN     = DATA_LEN_DEF,
  parameter int BURST_LEN    = BURST_LEN_DEF,
  parameter int MEM_ADDR_LEN = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SLAVE_LEN-1:0] slave_select,
  input  logic                 master_valid,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic                 rx_address,
  input  logic                 rx_burst_number,
  input  logic                 rx_data,
  input  logic                 master_ready,
  output logic                 slave_ready,
  output logic                 slave_valid,
  output logic                 tx_data,
  output logic                 done
`ifdef SLAVE_PORT_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

`ifdef SLAVE_PORT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_LEN = DATA_LEN + PAR_W;
  localparam int CNT_W    = cnt_width((ADDR_LEN > WORD_LEN) ? ADDR_LEN : WORD_LEN);

  localparam logic [CNT_W-1:0]     HDR_LAST   = CNT_W'(ADDR_LEN - 1);
  localparam logic [CNT_W-1:0]     WORD_LAST  = CNT_W'(WORD_LEN - 1);
  localparam logic [CNT_W-1:0]     BURST_BITS = CNT_W'(BURST_LEN);
  localparam logic [BURST_LEN-1:0] ONE_BEAT   = BURST_LEN'(1);

  state_e                  state_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [ADDR_LEN-2:0]     addr_q;
  logic [BURST_LEN-1:0]    burst_q;
  logic [BURST_LEN-1:0]    beats_q;
  logic [MEM_ADDR_LEN-1:0] idx_q;
  logic [WORD_LEN-1:0]     shift_q;
  logic                    is_write_q;
  logic                    slave_ready_q;
  logic                    slave_valid_q;
  logic                    done_q;

  logic [ADDR_LEN-1:0]     addr_d;
  logic [BURST_LEN-1:0]    burst_d;
  logic [MEM_ADDR_LEN-1:0] idx_inc;
  logic [MEM_ADDR_LEN-1:0] mem_addr;
  logic [DATA_LEN-1:0]     mem_rdata;
  logic [WORD_LEN-1:0]     fetch_word;
  logic                    beat;
  logic                    hs;
  logic                    rd_last;
  logic                    start;
  logic                    par_ok;
  logic                    mem_we;

  assign beat    = master_valid & slave_ready_q;
  assign hs      = slave_valid_q & master_ready;
  assign start   = master_valid && (slave_select == SLAVE_LEN'(SLAVE_ID)) && (write_en ^ read_en);
  assign rd_last = (state_q == ST_RD_DATA) && hs && (bit_cnt_q == WORD_LAST);
  assign idx_inc = idx_q + MEM_ADDR_LEN'(1);

  // Both header fields arrive LSB first; the burst field stops shifting once full.
  assign addr_d  = {rx_address, addr_q};
  assign burst_d = (bit_cnt_q < BURST_BITS) ? {rx_burst_number, burst_q[BURST_LEN-1:1]} : burst_q;

`ifdef SLAVE_PORT_PARITY_EN
  assign par_ok     = ~^shift_q;
  assign fetch_word = {^mem_rdata, mem_rdata};
`else
  assign par_ok     = 1'b1;
  assign fetch_word = mem_rdata;
`endif

  assign mem_we = (state_q == ST_WR_COMMIT) && par_ok;

  // The read port is registered, so present the index one cycle ahead of RD_FETCH.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_addr = idx_q;
    if (state_q == ST_RX_HDR) mem_addr = addr_d[MEM_ADDR_LEN-1:0];
    else if (rd_last)         mem_addr = idx_inc;
  end

  slave_mem #(
    .ADDR_W(MEM_ADDR_LEN),
    .DATA_W(DATA_LEN)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(shift_q[DATA_LEN-1:0]),
    .rdata_o(mem_rdata)
  );

  // NOTE: all state updates use non-blocking assignments so every branch
  // sees the register values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      addr_q        <= '0;
      burst_q       <= '0;
      beats_q       <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      is_write_q    <= 1'b0;
      slave_ready_q <= 1'b1;
      slave_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q     <= addr_d[ADDR_LEN-1:1];
            burst_q    <= burst_d;
            bit_cnt_q  <= CNT_W'(1);
            is_write_q <= write_en;
            state_q    <= ST_RX_HDR;
          end
        end
        ST_RX_HDR: begin
          if (beat) begin
            addr_q  <= addr_d[ADDR_LEN-1:1];
            burst_q <= burst_d;
            if (bit_cnt_q == HDR_LAST) begin
              bit_cnt_q <= '0;
              idx_q     <= addr_d[MEM_ADDR_LEN-1:0];
              beats_q   <= (burst_d == '0) ? ONE_BEAT : burst_d;
              if (is_write_q) begin
                state_q <= ST_WR_DATA;
              end else begin
                state_q       <= ST_RD_FETCH;
                slave_ready_q <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WR_DATA: begin
          if (beat) begin
            shift_q <= {rx_data, shift_q[WORD_LEN-1:1]};
            if (bit_cnt_q == WORD_LAST) begin
              bit_cnt_q     <= '0;
              slave_ready_q <= 1'b0;
              state_q       <= ST_WR_COMMIT;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WR_COMMIT: begin
          idx_q   <= idx_inc;
          beats_q <= beats_q - ONE_BEAT;
          if (beats_q == ONE_BEAT) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            slave_ready_q <= 1'b1;
            state_q       <= ST_WR_DATA;
          end
        end
        ST_RD_FETCH: begin
          shift_q       <= fetch_word;
          slave_valid_q <= 1'b1;
          state_q       <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (hs) begin
            shift_q <= {1'b0, shift_q[WORD_LEN-1:1]};
            if (bit_cnt_q == WORD_LAST) begin
              bit_cnt_q     <= '0;
              idx_q         <= idx_inc;
              beats_q       <= beats_q - ONE_BEAT;
              slave_valid_q <= 1'b0;
              if (beats_q == ONE_BEAT) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                state_q <= ST_RD_FETCH;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          slave_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: begin
          slave_ready_q <= 1'b1;
          slave_valid_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SLAVE_PORT_PARITY_EN
  // Sticky: only reset clears a detected write-parity error.
  logic parity_err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 parity_err_q <= 1'b0;
    else if (state_q == ST_WR_COMMIT && !par_ok) parity_err_q <= 1'b1;
  end
  assign parity_err = parity_err_q;
`endif

  assign slave_ready = slave_ready_q;
  assign slave_valid = slave_valid_q;
  assign tx_data     = slave_valid_q & shift_q[0];
  assign done        = done_q;

endmodule

// File: tb/tb_slave_port.sv
// Self-checking bench for slave_port: write bursts update a memory model,
// read bursts push expected serial bits into a scoreboard compared on output.
module tb_slave_port;

  localparam int ID = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] slave_select;
  logic       master_valid, write_en, read_en;
  logic       rx_address, rx_burst_number, rx_data, master_ready;
  logic       slave_ready, slave_valid, tx_data, done;
`ifdef SLAVE_PORT_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  slave_port #(
    .SLAVE_LEN   (2),
    .SLAVE_ID    (ID),
    .ADDR_LEN    (12),
    .DATA_LEN    (8),
    .BURST_LEN   (12),
    .MEM_ADDR_LEN(11)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .slave_select   (slave_select),
    .master_valid   (master_valid),
    .write_en       (write_en),
    .read_en        (read_en),
    .rx_address     (rx_address),
    .rx_burst_number(rx_burst_number),
    .rx_data        (rx_data),
    .master_ready   (master_ready),
    .slave_ready    (slave_ready),
    .slave_valid    (slave_valid),
    .tx_data        (tx_data),
    .done           (done)
`ifdef SLAVE_PORT_PARITY_EN
    ,
    .parity_err     (parity_err)
`endif
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] model [0:2047];
  logic [7:0] wdata [0:3];
  logic       sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slave_select    = 2'(ID);
    master_valid    = 1'b0;
    write_en        = 1'b0;
    read_en         = 1'b0;
    rx_address      = 1'b0;
    rx_burst_number = 1'b0;
    rx_data         = 1'b0;
    master_ready    = 1'b0;
  endtask

  // Twelve header beats; a stall of three idle cycles is inserted before beat stall_at.
  task automatic hdr(input logic [1:0] sel, input logic we, input logic re,
                     input logic [11:0] addr, input logic [11:0] burst, input int stall_at);
    for (int i = 0; i < 12; i++) begin
      if (i == stall_at) begin
        master_valid = 1'b0;
        repeat (3) tick();
      end
      check("hdr_rdy", slave_ready, 1);
      slave_select    = sel;
      write_en        = we;
      read_en         = re;
      master_valid    = 1'b1;
      rx_address      = addr[i];
      rx_burst_number = burst[i];
      tick();
    end
    master_valid = 1'b0;
    write_en     = 1'b0;
    read_en      = 1'b0;
  endtask

  task automatic wr_word(input logic [7:0] w);
    for (int b = 0; b < 8; b++) begin
      check("wr_rdy", slave_ready, 1);
      check("no_done", done, 0);
      master_valid = 1'b1;
      rx_data      = w[b];
      tick();
    end
    master_valid = 1'b0;
    check("commit_rdy", slave_ready, 0);
  endtask

  task automatic write_burst(input logic [11:0] addr, input logic [11:0] burst,
                             input int n, input int stall_at);
    logic [10:0] ix;
    hdr(2'(ID), 1'b1, 1'b0, addr, burst, stall_at);
    for (int k = 0; k < n; k++) begin
      wr_word(wdata[k]);
      ix        = addr[10:0] + 11'(k);
      model[ix] = wdata[k];
      tick();
      if (k < n - 1) begin
        check("commit_gap", slave_ready, 1);
      end else begin
        check("wr_done", done, 1);
        tick();
        check("done_pulse", done, 0);
        check("idle_rdy", slave_ready, 1);
      end
    end
  endtask

  task automatic read_burst(input logic [11:0] addr, input logic [11:0] burst,
                            input int n, input bit toggle, input int stall_at);
    logic [10:0] ix;
    logic        mr;
    int          cyc;
    for (int k = 0; k < n; k++) begin
      ix = addr[10:0] + 11'(k);
      for (int b = 0; b < 8; b++) sb.push_back(model[ix][b]);
    end
    hdr(2'(ID), 1'b0, 1'b1, addr, burst, stall_at);
    check("fetch_valid", slave_valid, 0);
    check("fetch_rdy", slave_ready, 0);
    tick();
    check("first_valid", slave_valid, 1);
    cyc = 0;
    while (sb.size() > 0 && cyc < 200) begin
      mr           = toggle ? (cyc % 2 == 1) : 1'b1;
      master_ready = mr;
      if (slave_valid) begin
        check("rd_bit", tx_data, sb[0]);
        if (mr) void'(sb.pop_front());
      end
      tick();
      cyc++;
    end
    master_ready = 1'b0;
    check("rd_drain", sb.size(), 0);
    sb.delete();
    check("rd_done", done, 1);
    tick();
    check("done_pulse", done, 0);
    check("idle_rdy", slave_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, slave_ready, 1);
    check({tag, "_valid"}, slave_valid, 0);
    check({tag, "_tx"}, tx_data, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // Burst write then read-back
    wdata[0] = 8'hA1; wdata[1] = 8'hB2; wdata[2] = 8'hC3;
    write_burst(12'h005, 12'd3, 3, -1);
    read_burst(12'h005, 12'd3, 3, 1'b0, -1);

    // Wrong select, then both enables: must be ignored
    slave_select = 2'd2; read_en = 1'b1; master_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      check("flt_sel_rdy", slave_ready, 1);
      check("flt_sel_done", done, 0);
    end
    slave_select = 2'(ID); write_en = 1'b1; read_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      check("flt_both_rdy", slave_ready, 1);
      check("flt_both_done", done, 0);
    end
    idle_inputs();
    tick();

    // Read with master_ready toggling
    wdata[0] = 8'h5A;
    write_burst(12'h010, 12'd1, 1, -1);
    read_burst(12'h010, 12'd1, 1, 1'b1, -1);

    // Index wrap-around
    wdata[0] = 8'h11; wdata[1] = 8'h22;
    write_burst(12'h7FF, 12'd2, 2, -1);
    read_burst(12'h7FF, 12'd2, 2, 1'b0, -1);
    read_burst(12'h000, 12'd1, 1, 1'b0, -1);

    // Burst 0 behaves as 1; header stalls; upper address bits ignored
    wdata[0] = 8'h3C;
    write_burst(12'h820, 12'd0, 1, 5);
    read_burst(12'h020, 12'd0, 1, 1'b0, 6);

    // Reset during word 2 of a 3-word write
    wdata[0] = 8'hE1; wdata[1] = 8'hE2;
    write_burst(12'h041, 12'd2, 2, -1);
    hdr(2'(ID), 1'b1, 1'b0, 12'h040, 12'd3, -1);
    wr_word(8'h77);
    model[11'h040] = 8'h77;
    tick();
    check("rst_gap", slave_ready, 1);
    for (int b = 0; b < 4; b++) begin
      master_valid = 1'b1;
      rx_data      = b[0];
      tick();
    end
    reset = 1'b0;
    #2;
    check_reset_outputs("abort");
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    read_burst(12'h040, 12'd3, 3, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slave_port.md
# slave_port

Serial bus slave endpoint: the responder at the far end of the master port's bit-serial address/data/burst lines. It decodes its slave select, shifts in a header of address and burst count, then either writes a burst of serially received words into a local register memory or reads words out and shifts them back with a `slave_valid`/`master_ready` handshake. One instance sits behind each slave select on the system bus.

## Interface
- `SLAVE_LEN`, 2: slave select width
- `SLAVE_ID`, 0: select value this instance answers to
- `ADDR_LEN`, 12: serial address bits per header
- `DATA_LEN`, 8: bits per data word
- `BURST_LEN`, 12: burst count bits; must be ≤ `ADDR_LEN`
- `MEM_ADDR_LEN`, 11: local memory index width; depth is 2^`MEM_ADDR_LEN`

- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `slave_select` in `SLAVE_LEN`: target slave from the master
- `master_valid` in 1: master serial bits valid
- `write_en` in 1: write transaction
- `read_en` in 1: read transaction
- `rx_address` in 1: serial address, LSB first
- `rx_burst_number` in 1: serial burst count, LSB first
- `rx_data` in 1: serial write data, LSB first
- `master_ready` in 1: master accepts the read bit
- `slave_ready` out 1: slave accepts the master's bits
- `slave_valid` out 1: `tx_data` valid
- `tx_data` out 1: serial read data, LSB first
- `done` out 1: one-cycle pulse at transaction end

## Operation
- **States:** IDLE, RX_HDR, WR_DATA, WR_COMMIT, RD_FETCH, RD_DATA, DONE.
- **Master beat:** the slave accepts a master bit only when `master_valid && slave_ready`. `slave_ready`=1 in IDLE, RX_HDR and WR_DATA, and 0 in all other states. If `master_valid` drops, the bit counters hold.
- **Start (IDLE):**
  - Condition: `master_valid`=1, `slave_select`==`SLAVE_ID`, and exactly one of `write_en`/`read_en` set.
  - That cycle's address and burst bits are header bit 0. The latched direction is held for the whole transaction.
  - Both enables set, or a non-matching select: the request is ignored and the slave stays in IDLE.
- **RX_HDR:**
  - Runs for `ADDR_LEN` accepted beats total.
  - `rx_burst_number` is captured on the first `BURST_LEN` beats; the remaining bits are ignored.
  - The final beat moves to WR_DATA (write) or RD_FETCH (read).
  - The memory index is `address[MEM_ADDR_LEN-1:0]`; upper address bits are ignored.
  - A burst count of 0 is treated as 1.
- **WR_DATA:**
  - Shifts in `DATA_LEN` accepted bits, then goes to WR_COMMIT.
  - WR_COMMIT writes the word and increments the index modulo depth, so a burst wraps from 2^`MEM_ADDR_LEN`-1 to 0.
  - It then decrements the beat count and goes to WR_DATA, or to DONE if the count reaches 0.
- **RD_FETCH:** loads the shift register from memory at the current index.
- **RD_DATA:**
  - `slave_valid`=1 and `tx_data` = shift register LSB.
  - On `slave_valid && master_ready` the register shifts.
  - After `DATA_LEN` handshakes: increment the index (wrapping) and decrement the beat count, then go to RD_FETCH, or to DONE when the count reaches 0.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Reset:** asserted at any time, it aborts immediately; words already committed stay in memory. Memory contents are not reset.
- **Reset values:** state IDLE, `slave_ready`=1, `slave_valid`=0, `tx_data`=0, `done`=0, all counters 0.

## Timing
- Header: exactly `ADDR_LEN` accepted beats; the start cycle counts as beat 0.
- Write: each word takes `DATA_LEN` accepted beats plus 1 WR_COMMIT cycle with `slave_ready`=0.
- Read: the last header beat is followed by 1 RD_FETCH cycle. The first `slave_valid` appears on the next cycle, i.e. 2 cycles after the last header beat.
- Between read words there is 1 RD_FETCH gap with `slave_valid`=0.
- `done` asserts one cycle after the final commit or the final read handshake. `slave_ready`=1 again on the following cycle.
- A new start is accepted in the cycle that IDLE is re-entered.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.

## Configuration
- `SLAVE_PORT_PARITY_EN` defined:
  - Every data word carries `DATA_LEN`+1 bits; the extra bit is even parity and comes last.
  - Write: a parity mismatch skips the memory write for that beat (the index still advances) and sets a sticky output `parity_err` (out, 1 bit, reset 0; cleared only by reset).
  - Read: the slave appends the parity bit.
- Undefined: words are `DATA_LEN` bits and the `parity_err` port does not exist.

## Structure
- Shared package `bus_pkg`: state enum, `ADDR_LEN`/`DATA_LEN`/`BURST_LEN`/`SLAVE_LEN` defaults, and the bit-count width function.
- Sub-module `slave_mem`: a single-port register array with synchronous write and registered read, instantiated once.
- Shift registers and the FSM live in `slave_port`.

## Test plan
- Write burst: `SLAVE_ID`=1, address 0x005, burst 3, data 0xA1/0xB2/0xC3 → read back 0xA1/0xB2/0xC3 at index 5..7; `done` pulses once per transaction.
- Select and enable filtering: select 2 on a `SLAVE_ID`=1 instance, then both `write_en` and `read_en` high → `slave_ready` stays 1, no state change, no `done`.
- Read with stalls: memory[0x010]=0x5A, burst 1, `master_ready` toggling every cycle → `tx_data` bits 0,1,0,1,1,0,1,0 over 8 handshakes, each bit held while stalled.
- Wrap-around: write burst 2 at index 0x7FF with 0x11/0x22 → memory[0x7FF]=0x11, memory[0x000]=0x22.
- Burst 0 and header stall: burst count 0 with `master_valid` low for 3 cycles mid-header → exactly one word transferred, header completes after 12 accepted beats.
- Reset mid-burst: `reset` low during word 2 of a 3-word write → outputs return to reset values; word 1 is retained and words 2–3 are not written.
